// File: rtl/knap_dp_engine_if.sv
// Table-memory bus between the knapsack DP engine (master) and the DP table RAM (slave).
// Read data is registered by the memory: valid the cycle after mem_rd_en, 0 otherwise.
interface knap_dp_engine_if;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, input  mem_rdata);
  modport slave  (input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata, output mem_rdata);
endinterface

// File: rtl/knap_dp_engine.sv
// 0/1-knapsack item update engine: dp[c] = max(dp[c], dp[c-w]+v) for c = CAP down to w, 4 cycles per c.
// Optional table clear is compiled in with DP_CLEAR_EN.
module knap_dp_engine #(
  parameter int CAP       = 511,
  parameter int BASE_ADDR = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [15:0]        i_item_w,
  input  logic [31:0]        i_item_v,
  input  logic               i_clr,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [31:0]        o_best,
  knap_dp_engine_if.master   mem
);

  localparam logic [15:0] CAP_C  = 16'(CAP);
  localparam logic [15:0] BASE_C = 16'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_WR, S_FIN
`ifdef DP_CLEAR_EN
    , S_CLR
`endif
  } state_t;

  state_t      r_state;
  logic [15:0] r_c;
  logic [15:0] r_w;
  logic [31:0] r_v;
  logic [31:0] r_old;
  logic [31:0] r_cand;

  // mem_rdata holds dp[c-w] while in CAP_B; candidate saturates instead of wrapping
  logic [32:0] w_sum;
  logic [31:0] w_cand;
  assign w_sum  = {1'b0, mem.mem_rdata} + {1'b0, r_v};
  assign w_cand = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];

`ifndef DP_CLEAR_EN
  logic w_unused_clr;
  assign w_unused_clr = i_clr;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_c           <= '0;
      r_w           <= '0;
      r_v           <= '0;
      r_old         <= '0;
      r_cand        <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_best        <= '0;
      mem.mem_addr  <= '0;
      mem.mem_rd_en <= 1'b0;
      mem.mem_wr_en <= 1'b0;
      mem.mem_wdata <= '0;
    end else begin
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      mem.mem_rd_en <= 1'b0;
      mem.mem_wr_en <= 1'b0;
      case (r_state)
        // FIN doubles as IDLE so a start can be taken in the done cycle
        S_IDLE, S_FIN: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (i_start) begin
            if (i_item_w == 16'd0) begin
              o_err <= 1'b1;
            end else if (i_item_w > CAP_C) begin
              o_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_w           <= i_item_w;
              r_v           <= i_item_v;
              r_c           <= CAP_C;
              o_busy        <= 1'b1;
              mem.mem_addr  <= BASE_C + CAP_C;
              mem.mem_rd_en <= 1'b1;
              r_state       <= S_RD_A;
            end
          end
`ifdef DP_CLEAR_EN
          else if (i_clr) begin
            r_c           <= '0;
            o_busy        <= 1'b1;
            mem.mem_addr  <= BASE_C;
            mem.mem_wr_en <= 1'b1;
            mem.mem_wdata <= '0;
            r_state       <= S_CLR;
          end
`endif
        end
        S_RD_A: begin
          mem.mem_addr  <= BASE_C + r_c - r_w;
          mem.mem_rd_en <= 1'b1;
          r_state       <= S_RD_B;
        end
        S_RD_B: begin
          r_old   <= mem.mem_rdata;
          r_state <= S_CAP_B;
        end
        S_CAP_B: begin
          r_cand       <= w_cand;
          mem.mem_addr <= BASE_C + r_c;
          if (w_cand > r_old) begin
            mem.mem_wr_en <= 1'b1;
            mem.mem_wdata <= w_cand;
          end
          r_state <= S_WR;
        end
        S_WR: begin
          if (r_c == CAP_C)
            o_best <= (r_cand > r_old) ? r_cand : r_old;
          if (r_c == r_w) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_c           <= r_c - 16'd1;
            mem.mem_addr  <= BASE_C + r_c - 16'd1;
            mem.mem_rd_en <= 1'b1;
            r_state       <= S_RD_A;
          end
        end
`ifdef DP_CLEAR_EN
        S_CLR: begin
          if (r_c == CAP_C) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_best  <= '0;
            r_state <= S_FIN;
          end else begin
            r_c           <= r_c + 16'd1;
            mem.mem_addr  <= mem.mem_addr + 16'd1;
            mem.mem_wr_en <= 1'b1;
            mem.mem_wdata <= '0;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knap_dp_engine.sv
// Self-checking bench for knap_dp_engine: table RAM model plus a row-level knapsack reference.
module tb_knap_dp_engine;
  localparam int CAP  = 7;
  localparam int BASE = 1;
  localparam int LIM  = 4 * (CAP + 1) + 12;

  logic        clk = 1'b0;
  logic        rst, start, clr;
  logic [15:0] item_w;
  logic [31:0] item_v;
  logic        busy, done, err;
  logic [31:0] best;

  knap_dp_engine_if mem_bus();

  knap_dp_engine #(.CAP(CAP), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_item_w(item_w), .i_item_v(item_v),
    .i_clr(clr), .o_busy(busy), .o_done(done), .o_err(err), .o_best(best), .mem(mem_bus)
  );

  always #5 clk = ~clk;

  // table RAM model with bus monitors
  logic [31:0] tmem [0:15];
  logic        poke_en;
  logic [3:0]  poke_a;
  logic [31:0] poke_d;
  int          strobes, viol;
  logic [15:0] wr_q [$];

  always @(posedge clk) begin
    if (poke_en) tmem[poke_a] <= poke_d;
    if (mem_bus.mem_wr_en) begin
      tmem[mem_bus.mem_addr[3:0]] <= mem_bus.mem_wdata;
      wr_q.push_back(mem_bus.mem_addr);
    end
    mem_bus.mem_rdata <= mem_bus.mem_rd_en ? tmem[mem_bus.mem_addr[3:0]] : 32'd0;
    if (mem_bus.mem_rd_en || mem_bus.mem_wr_en) begin
      strobes <= strobes + 1;
      if ((mem_bus.mem_rd_en && mem_bus.mem_wr_en) ||
          mem_bus.mem_addr < 16'(BASE) || mem_bus.mem_addr > 16'(BASE + CAP))
        viol <= viol + 1;
    end
  end

  int          checks, errors;
  logic [31:0] ref_dp [0:CAP];
  logic [31:0] ref_best;
  logic [15:0] exp_wr [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // whole-row 0/1 knapsack update from a snapshot of the previous row
  task automatic ref_apply(input int w, input logic [31:0] v, input int steps);
    logic [31:0]     old [0:CAP];
    longint unsigned s;
    logic [31:0]     cand;
    int              c, k;
    old = ref_dp;
    exp_wr.delete();
    c = CAP;
    k = steps;
    while (c >= w && k > 0) begin
      s    = longint'(old[c-w]) + longint'(v);
      cand = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
      if (cand > old[c]) begin
        ref_dp[c] = cand;
        exp_wr.push_back(16'(BASE + c));
      end
      if (c == CAP) ref_best = (cand > old[c]) ? cand : old[c];
      c--;
      k--;
    end
  endtask

  task automatic sync_mem;
    for (int c = 0; c <= CAP; c++) begin
      poke_a  = 4'(BASE + c);
      poke_d  = ref_dp[c];
      poke_en = 1'b1;
      @(negedge clk);
    end
    poke_en = 1'b0;
  endtask

  task automatic check_row(input string tag);
    for (int c = 0; c <= CAP; c++)
      chk($sformatf("%s dp[%0d]", tag, c), tmem[BASE+c], ref_dp[c]);
  endtask

  // called at a negedge; returns at the negedge of the done cycle (start may follow at once)
  task automatic do_item(input logic [15:0] w, input logic [31:0] v, input string tag);
    int s0, q0, v0, cyc, dcyc, ecyc, bcnt, n;
    logic busy_at_done;
    s0 = strobes; q0 = wr_q.size(); v0 = viol;
    dcyc = 0; ecyc = 0; bcnt = 0; busy_at_done = 1'b0;
    item_w = w; item_v = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= LIM) begin
      if (busy) bcnt++;
      if (done && dcyc == 0) begin dcyc = cyc; busy_at_done = busy; end
      if (err && ecyc == 0) ecyc = cyc;
      if (dcyc != 0 || ecyc != 0) break;
      @(negedge clk);
      cyc++;
    end
    if (w == 16'd0) begin
      chk({tag, " err cycle"}, ecyc, 1);
      chk({tag, " no done"}, dcyc, 0);
      repeat (2) @(negedge clk);
      chk({tag, " err one pulse"}, err, 1'b0);
      chk({tag, " no strobes"}, strobes - s0, 0);
    end else if (int'(w) > CAP) begin
      chk({tag, " done cycle"}, dcyc, 1);
      chk({tag, " busy cycles"}, bcnt, 0);
      chk({tag, " no err"}, ecyc, 0);
      repeat (2) @(negedge clk);
      chk({tag, " no strobes"}, strobes - s0, 0);
    end else begin
      n = CAP - int'(w) + 1;
      ref_apply(int'(w), v, n);
      chk({tag, " done cycle"}, dcyc, 4 * n + 1);
      chk({tag, " busy cycles"}, bcnt, 4 * n);
      chk({tag, " busy at done"}, busy_at_done, 1'b0);
      chk({tag, " write count"}, wr_q.size() - q0, exp_wr.size());
      for (int i = 0; i < exp_wr.size() && q0 + i < wr_q.size(); i++)
        chk($sformatf("%s write %0d addr", tag, i), wr_q[q0+i], exp_wr[i]);
      check_row(tag);
    end
    chk({tag, " best"}, best, ref_best);
    chk({tag, " bus rules"}, viol - v0, 0);
  endtask

  initial begin
    int s0, q0, cyc, bcnt, dcyc;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; clr = 1'b0; item_w = '0; item_v = '0;
    poke_en = 1'b0; poke_a = '0; poke_d = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst best", best, 32'd0);
    chk("rst addr", mem_bus.mem_addr, 16'd0);
    chk("rst rd_en", mem_bus.mem_rd_en, 1'b0);
    chk("rst wr_en", mem_bus.mem_wr_en, 1'b0);
    chk("rst wdata", mem_bus.mem_wdata, 32'd0);
    rst = 1'b0;
    for (int c = 0; c <= CAP; c++) ref_dp[c] = 32'd0;
    ref_best = 32'd0;
    sync_mem();

    // directed items; second item starts in the done cycle of the first
    do_item(16'd3, 32'd5, "tp1");
    chk("tp1 best const", best, 32'd5);
    do_item(16'd4, 32'd6, "tp2");
    chk("tp2 best const", best, 32'd11);
    chk("tp2 dp3 kept", tmem[BASE+3], 32'd5);

    ref_dp = '{32'hFFFF_FFF0, 32'd1, 32'd5, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0};
    sync_mem();
    do_item(16'd2, 32'h20, "sat");
    chk("sat dp2", tmem[BASE+2], 32'hFFFF_FFFF);

    ref_dp = '{32'd0, 32'd0, 32'd10, 32'd10, 32'd20, 32'd20, 32'd30, 32'd30};
    sync_mem();
    do_item(16'd2, 32'd10, "equal");
    do_item(16'd0, 32'd9, "w0");
    do_item(16'd9, 32'd9, "wbig");

    // reset during RD_B of the second capacity step
    for (int c = 0; c <= CAP; c++) ref_dp[c] = 32'd0;
    sync_mem();
    item_w = 16'd3; item_v = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid rd addr", mem_bus.mem_addr, 16'(BASE + 3));
    chk("mid rd_en", mem_bus.mem_rd_en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("arst rd_en", mem_bus.mem_rd_en, 1'b0);
    chk("arst wr_en", mem_bus.mem_wr_en, 1'b0);
    chk("arst busy", busy, 1'b0);
    chk("arst done", done, 1'b0);
    chk("arst best", best, 32'd0);
    ref_apply(3, 32'd5, 1);
    ref_best = 32'd0;
    check_row("arst");
    do_item(16'd3, 32'd5, "post rst");

    for (int it = 0; it < 8; it++) begin
      if (it % 2 == 0) begin
        for (int c = 0; c <= CAP; c++)
          ref_dp[c] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200));
        sync_mem();
      end
      do_item(16'($urandom_range(1, CAP + 2)),
              ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 100)),
              $sformatf("rnd%0d", it));
    end

    // table clear request
    @(negedge clk);
    s0 = strobes; q0 = wr_q.size(); bcnt = 0; dcyc = 0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cyc = 1;
    while (cyc <= LIM && dcyc == 0) begin
      if (busy) bcnt++;
      if (done) dcyc = cyc;
      if (dcyc == 0) begin @(negedge clk); cyc++; end
    end
`ifdef DP_CLEAR_EN
    for (int c = 0; c <= CAP; c++) ref_dp[c] = 32'd0;
    ref_best = 32'd0;
    chk("clr done cycle", dcyc, CAP + 2);
    chk("clr busy cycles", bcnt, CAP + 1);
    chk("clr write count", wr_q.size() - q0, CAP + 1);
    for (int i = 0; i <= CAP && q0 + i < wr_q.size(); i++)
      chk($sformatf("clr write %0d addr", i), wr_q[q0+i], 16'(BASE + i));
    check_row("clr");
    chk("clr best", best, 32'd0);
`else
    chk("clr no done", dcyc, 0);
    chk("clr no busy", bcnt, 0);
    chk("clr no strobes", strobes - s0, 0);
    chk("clr best kept", best, ref_best);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
